// File: rtl/decode_stage.sv
// RV32I(+M) decode stage: combinational decode into a microcode address,
// registered through a valid/ready output register backed by a one-entry skid buffer.
module decode_stage #(
  parameter int unsigned UADDR_W = 7,
  parameter bit          EN_M    = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [31:0]        in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [UADDR_W-1:0] out_uaddr,
  output logic [24:0]        out_data,
  output logic [31:0]        out_pc,
  output logic               out_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic        illegal;
    logic [6:0]  uaddr;
    logic [24:0] data;
    logic [31:0] pc;
  } entry_t;

  entry_t     in_entry, or_q, sk_q;
  logic       or_valid, sk_valid;
  logic       accept;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       alt;
  logic       legal;
  logic [6:0] addr;

  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];
  assign alt = in_instr[30];

  always_comb begin
    legal = 1'b0;
    addr  = '0;
    unique case (in_instr[6:0])
      OPC_LUI:    begin legal = 1'b1;           addr = 7'h01; end
      OPC_AUIPC:  begin legal = 1'b1;           addr = 7'h02; end
      OPC_JAL:    begin legal = 1'b1;           addr = 7'h03; end
      OPC_JALR:   begin legal = (f3 == 3'b000); addr = 7'h04; end
      OPC_FENCE:  begin legal = (f3 == 3'b000); addr = 7'h05; end
      OPC_SYSTEM: begin legal = (f3 == 3'b000); addr = 7'h06; end
      OPC_BRANCH: begin
        legal = (f3 != 3'b010) && (f3 != 3'b011);
        addr  = {4'b0001, f3};
      end
      OPC_LOAD: begin
        legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
        addr  = {4'b0010, f3};
      end
      OPC_STORE: begin
        legal = (f3 <= 3'b010);
        addr  = {4'b0011, f3};
      end
      OPC_OPIMM: begin
        // only shifts constrain funct7; alt selects SRAI over SRLI
        if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
        else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        else                   legal = 1'b1;
        addr = {2'b01, alt && (f3 == 3'b101), 1'b0, f3};
      end
      OPC_OP: begin
        if (f7 == 7'b0000000) begin
          legal = 1'b1;
          addr  = {4'b0101, f3};
        end else if (f7 == 7'b0100000) begin
          legal = (f3 == 3'b000) || (f3 == 3'b101);
          addr  = {4'b0111, f3};
        end else if (f7 == 7'b0000001) begin
          legal = EN_M;
          addr  = {4'b1000, f3};
        end
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    in_entry.illegal = !legal;
    in_entry.uaddr   = legal ? addr : '0;
    in_entry.data    = in_instr[31:7];
    in_entry.pc      = in_pc;
  end

  assign in_ready = !sk_valid && !flush;
  assign accept   = in_valid && in_ready;

  // SK can only be full when in_ready is low, so a draining SK never coincides with an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_valid <= 1'b0;
      sk_valid <= 1'b0;
      or_q     <= '0;
      sk_q     <= '0;
    end else if (flush) begin
      or_valid <= 1'b0;
      sk_valid <= 1'b0;
    end else if (!or_valid || out_ready) begin
      if (sk_valid) begin
        or_q     <= sk_q;
        or_valid <= 1'b1;
        sk_valid <= 1'b0;
      end else begin
        or_valid <= accept;
        if (accept) or_q <= in_entry;
      end
    end else if (accept) begin
      sk_q     <= in_entry;
      sk_valid <= 1'b1;
    end
  end

  always_comb begin
    out_uaddr      = '0;
    out_uaddr[6:0] = or_q.uaddr;
  end

  assign out_valid   = or_valid;
  assign out_data    = or_q.data;
  assign out_pc      = or_q.pc;
  assign out_illegal = or_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: queue-based reference model with a per-cycle compare process,
// plus directed scenarios with literal expectations; two instances cover EN_M=1 and EN_M=0.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;

  logic        in_ready, out_valid, out_illegal;
  logic [6:0]  out_uaddr;
  logic [24:0] out_data;
  logic [31:0] out_pc;
  logic        nm_in_ready, nm_out_valid, nm_out_illegal;
  logic [6:0]  nm_out_uaddr;
  logic [24:0] nm_out_data;
  logic [31:0] nm_out_pc;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  decode_stage #(.UADDR_W(7), .EN_M(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_uaddr(out_uaddr),
    .out_data(out_data), .out_pc(out_pc), .out_illegal(out_illegal)
  );

  decode_stage #(.UADDR_W(7), .EN_M(1'b0)) dut_nm (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(nm_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(nm_out_valid), .out_ready(out_ready), .out_uaddr(nm_out_uaddr),
    .out_data(nm_out_data), .out_pc(nm_out_pc), .out_illegal(nm_out_illegal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decoder: returns {illegal, uaddr}.
  function automatic logic [7:0] ref_dec(input logic [31:0] i, input bit en_m);
    logic [2:0] f3;
    logic [6:0] f7;
    int a;
    bit ok;
    f3 = i[14:12];
    f7 = i[31:25];
    ok = 1'b1;
    a = 0;
    case (i[6:0])
      7'h37: a = 1;
      7'h17: a = 2;
      7'h6F: a = 3;
      7'h67: begin a = 4; ok = (f3 == 0); end
      7'h0F: begin a = 5; ok = (f3 == 0); end
      7'h73: begin a = 6; ok = (f3 == 0); end
      7'h63: begin a = 8 + f3; ok = !(f3 inside {3'd2, 3'd3}); end
      7'h03: begin a = 16 + f3; ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; end
      7'h23: begin a = 24 + f3; ok = (f3 <= 2); end
      7'h13: begin
        a = 32 + f3 + ((f3 == 5 && i[30]) ? 16 : 0);
        if (f3 == 1) ok = (f7 == 0);
        if (f3 == 5) ok = (f7 == 0) || (f7 == 7'h20);
      end
      7'h33: begin
        if (f7 == 0) a = 40 + f3;
        else if (f7 == 7'h20) begin a = 56 + f3; ok = (f3 == 0) || (f3 == 5); end
        else if (f7 == 7'h01) begin a = 64 + f3; ok = en_m; end
        else ok = 1'b0;
      end
      default: ok = 1'b0;
    endcase
    return ok ? {1'b0, 7'(a)} : 8'h80;
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;
  ent_t q[$];

  // Model: a FIFO of at most two accepted instructions.
  always @(posedge clk or negedge rst_n) begin
    int n;
    if (!rst_n || flush) q.delete();
    else begin
      n = q.size();
      if (n > 0 && out_ready) void'(q.pop_front());
      if (in_valid && n < 2) q.push_back('{in_instr, in_pc});
    end
  end

  bit          prev_stall = 1'b0;
  logic [6:0]  prev_uaddr;
  logic [24:0] prev_data;
  logic [31:0] prev_pc;
  logic        prev_ill;

  always @(negedge clk) begin
    logic [7:0] r1, r0;
    if (!rst_n) begin
      chk("reset_outputs", {out_valid, out_illegal, out_uaddr, out_data[0], out_pc, out_data, in_ready},
          {1'b0, 1'b0, 7'h0, 1'b0, 32'h0, 25'h0, 1'b1});
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", {nm_in_ready, in_ready}, {2{(q.size() < 2) && !flush}});
      chk("out_valid", {nm_out_valid, out_valid}, {2{q.size() > 0}});
      if (q.size() > 0) begin
        r1 = ref_dec(q[0].instr, 1'b1);
        r0 = ref_dec(q[0].instr, 1'b0);
        chk("uaddr", 32'(out_uaddr), 32'(r1[6:0]));
        chk("illegal", 32'(out_illegal), 32'(r1[7]));
        chk("data", 32'(out_data), 32'(q[0].instr[31:7]));
        chk("pc", out_pc, q[0].pc);
        chk("nm_uaddr", 32'(nm_out_uaddr), 32'(r0[6:0]));
        chk("nm_illegal", 32'(nm_out_illegal), 32'(r0[7]));
        chk("nm_pc", nm_out_pc, q[0].pc);
      end
      if (prev_stall && out_valid) begin
        chk("stall_stable_uaddr", 32'(out_uaddr), 32'(prev_uaddr));
        chk("stall_stable_data", 32'(out_data), 32'(prev_data));
        chk("stall_stable_pc", out_pc, prev_pc);
        chk("stall_stable_ill", 32'(out_illegal), 32'(prev_ill));
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_uaddr = out_uaddr;
      prev_data  = out_data;
      prev_pc    = out_pc;
      prev_ill   = out_illegal;
    end
  end

  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic rdy, input logic fl);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs[12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h0F, 7'h73,
                             7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h33};
    logic [6:0] f7s[4];
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 3) == 0) return w;
    f7s = '{7'h00, 7'h20, 7'h01, 7'($urandom)};
    w[6:0]   = opcs[$urandom_range(0, 11)];
    w[31:25] = f7s[$urandom_range(0, 3)];
    return w;
  endfunction

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] SRA  = 32'h40205033;
  localparam logic [31:0] MUL  = 32'h02208133;
  localparam logic [31:0] LUI  = 32'h000000B7;

  initial begin
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back stream with out_ready high
    cyc(1, ADDI, 32'h100, 1, 0);
    chk("d_addi_uaddr", 32'(out_uaddr), 32'h20);
    chk("d_addi_valid", 32'(out_valid), 32'h1);
    cyc(1, SRA, 32'h104, 1, 0);
    chk("d_sra_uaddr", 32'(out_uaddr), 32'h3D);
    chk("d_sra_ill", 32'(out_illegal), 32'h0);
    cyc(1, MUL, 32'h108, 1, 0);
    chk("d_mul_uaddr", 32'(out_uaddr), 32'h40);
    chk("d_mul_nm", {nm_out_illegal, nm_out_uaddr}, 32'h80);
    cyc(1, 32'h0000B003, 32'h10C, 1, 0);
    chk("d_ld011", {out_illegal, out_uaddr}, 32'h80);
    chk("d_ld011_data", 32'(out_data), 32'h160);
    chk("d_ld011_pc", out_pc, 32'h10C);
    cyc(1, 32'h00000001, 32'h110, 1, 0);
    chk("d_opc01", {out_illegal, out_uaddr}, 32'h80);
    cyc(0, 32'h0, 32'h0, 1, 0);
    chk("d_drained", 32'(out_valid), 32'h0);

    // Stall: A held, B in skid, C refused, then ordered drain
    cyc(1, ADDI, 32'h200, 0, 0);
    chk("s_a_out", out_pc, 32'h200);
    chk("s_ready1", 32'(in_ready), 32'h1);
    cyc(1, SRA, 32'h204, 0, 0);
    chk("s_ready0", 32'(in_ready), 32'h0);
    cyc(1, LUI, 32'h208, 0, 0);
    chk("s_a_hold", out_pc, 32'h200);
    chk("s_c_refused", 32'(in_ready), 32'h0);
    cyc(1, LUI, 32'h208, 1, 0);
    chk("s_b_out", out_pc, 32'h204);
    chk("s_ready_back", 32'(in_ready), 32'h1);
    cyc(1, LUI, 32'h208, 1, 0);
    chk("s_c_out", out_pc, 32'h208);
    chk("s_c_uaddr", 32'(out_uaddr), 32'h01);
    cyc(0, 32'h0, 32'h0, 1, 0);
    chk("s_empty", 32'(out_valid), 32'h0);

    // Flush with OR and SK full and a new instruction offered
    cyc(1, ADDI, 32'h300, 0, 0);
    cyc(1, SRA, 32'h304, 0, 0);
    cyc(1, LUI, 32'h308, 1, 1);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("f_valid", 32'(out_valid), 32'h0);
    chk("f_ready", 32'(in_ready), 32'h1);
    cyc(0, 32'h0, 32'h0, 1, 0);
    chk("f_still_empty", 32'(out_valid), 32'h0);

    // Asynchronous reset mid-stall
    cyc(1, ADDI, 32'h400, 0, 0);
    cyc(1, SRA, 32'h404, 0, 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("r_outputs", {out_valid, out_illegal, out_uaddr, out_pc}, 32'h0);
    chk("r_data", 32'(out_data), 32'h0);
    chk("r_ready", 32'(in_ready), 32'h1);
    #4 rst_n = 1'b1;
    cyc(1, LUI, 32'h500, 1, 0);
    chk("r_lui_uaddr", 32'(out_uaddr), 32'h01);
    chk("r_lui_valid", {out_valid, out_illegal}, 32'h2);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 9) < 7, rand_instr(), $urandom,
          $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 4);
    end
    for (int k = 0; k < 4; k++) cyc(0, 32'h0, 32'h0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
